// File: rtl/colc_128x1_writer.sv
// colc_128x1_writer: column-C write side. Stores a 17-bit sum stream into a
// 128-entry buffer, overwriting or saturating-accumulating each entry.
//
// Ports:
//   clk, resetn       rising-edge clock, async active-low reset
//   start, acc        one-cycle pass start; acc selects accumulate mode
//   in_valid, in_data sum beat stream; in_ready high while a pass runs
//   rd_adr, rd_data   registered read-back port (1-cycle latency)
//   busy, done, ovf   pass running, last pass finished, sticky saturation

module colc_128x1_writer #(
    parameter int DEPTH = 128,
    parameter int IN_W  = 17,
    parameter int ACC_W = 20
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     acc,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     in_ready,
    input  logic [$clog2(DEPTH)-1:0] rd_adr,
    output logic [ACC_W-1:0]         rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wadr_q, wadr_d;
    logic               mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic [ACC_W-1:0]   rd_data_q;

    logic [ACC_W-1:0]   mem [DEPTH];

    logic               accept;
    logic               we;
    logic [ACC_W-1:0]   wdata;
    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W:0]     sum;
    logic               sat;

    // in_ready_q is high exactly while in WRITE, so it gates acceptance.
    assign accept = in_valid & in_ready_q;
    assign in_ext = {{(ACC_W - IN_W){1'b0}}, in_data};

    // One extra bit catches the carry out of the accumulate.
    assign sum = {1'b0, mem[wadr_q]} + {1'b0, in_ext};
    assign sat = sum[ACC_W];

    always_comb begin
        state_d    = state_q;
        wadr_d     = wadr_q;
        mode_d     = mode_q;
        ovf_d      = ovf_q;
        done_d     = done_q;
        busy_d     = busy_q;
        in_ready_d = in_ready_q;
        we         = 1'b0;
        wdata      = in_ext;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_WRITE;
                    wadr_d     = '0;
                    mode_d     = acc;
                    ovf_d      = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    we     = 1'b1;
                    wadr_d = wadr_q + AW'(1);
                    if (mode_q) begin
                        if (sat) begin
                            wdata = '1;
                            ovf_d = 1'b1;
                        end else begin
                            wdata = sum[ACC_W-1:0];
                        end
                    end
                    if (wadr_q == LAST_ADR) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                wadr_d     = '0;
                busy_d     = 1'b0;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wadr_q     <= '0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wadr_q     <= wadr_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage carries no reset; entries survive a mid-pass reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wadr_q] <= wdata;
        end
    end

    // Non-blocking read samples the pre-write value on a same-address hit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_adr];
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_colc_128x1_writer.sv
// Testbench for colc_128x1_writer: directed passes with random data and gaps,
// checked against an array model of the column buffer.

module tb_colc_128x1_writer;

    localparam int MAXV = 20'hFFFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        acc = 1'b0;
    logic        in_valid = 1'b0;
    logic [16:0] in_data = '0;
    logic        in_ready;
    logic [6:0]  rd_adr = '0;
    logic [19:0] rd_data;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_chk = 0;
    int n_fail = 0;

    int unsigned ref_mem [128];
    int          mw = 0;
    bit          mode_m = 0;
    bit          ovf_m = 0;

    colc_128x1_writer dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .acc      (acc),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_adr   (rd_adr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit a);
        start = 1'b1;
        acc = a;
        tick();
        start = 1'b0;
        mw = 0;
        mode_m = a;
        ovf_m = 0;
        chk("start_busy", 32'(busy), 1);
        chk("start_ready", 32'(in_ready), 1);
        chk("start_done", 32'(done), 0);
        chk("start_ovf", 32'(ovf), 0);
    endtask

    task automatic beat(input logic [16:0] d, input bit with_start);
        int unsigned s;
        bit exp_done;
        chk("beat_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data = d;
        start = with_start;
        acc = ~mode_m;
        tick();
        in_valid = 1'b0;
        start = 1'b0;
        if (mode_m) begin
            s = ref_mem[mw] + d;
            if (s > MAXV) begin
                s = MAXV;
                ovf_m = 1;
            end
        end else begin
            s = d;
        end
        ref_mem[mw] = s;
        mw++;
        exp_done = (mw == 128);
        if (exp_done) mw = 0;
        chk("beat_done", 32'(done), 32'(exp_done));
        chk("beat_busy", 32'(busy), 32'(!exp_done));
        chk("beat_ovf", 32'(ovf), 32'(ovf_m));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 1);
            chk("idle_ready", 32'(in_ready), 1);
        end
    endtask

    task automatic rd_chk(input logic [6:0] a);
        rd_adr = a;
        tick();
        chk($sformatf("rd[%0d]", a), 32'(rd_data), ref_mem[a]);
    endtask

    // kind 0: data = index, 1: constant cval, 2: random; gaps inserts idles
    task automatic pass(input bit a, input int kind, input logic [16:0] cval,
                        input bit gaps);
        logic [16:0] d;
        do_start(a);
        for (int i = 0; i < 128; i++) begin
            case (kind)
                0: d = 17'(i);
                1: d = cval;
                default: d = 17'($urandom);
            endcase
            beat(d, 1'b0);
            if (gaps && i != 127 && $urandom_range(0, 3) == 0)
                idle(int'($urandom_range(1, 3)));
        end
    endtask

    task automatic rest_random();
        while (mw != 0 || busy) begin
            beat(17'($urandom), 1'b0);
            if (mw == 0) break;
        end
    endtask

    task automatic rd_all();
        for (int i = 0; i < 128; i++) rd_chk(7'(i));
    endtask

    initial begin
        logic [31:0] old3;

        // reset state
        #12;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_rd", 32'(rd_data), 0);
        resetn = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 0);

        // overwrite pass with index data
        pass(1'b0, 0, '0, 1'b0);
        rd_chk(7'd0);
        rd_chk(7'd5);
        rd_chk(7'd127);
        chk("done_level", 32'(done), 1);

        // accumulate 0x1FFFF: entry 5 = 0x20004, no saturation yet
        pass(1'b1, 1, 17'h1FFFF, 1'b0);
        chk("ent5_20004", ref_mem[5], 32'h20004);
        rd_chk(7'd5);
        chk("no_ovf", 32'(ovf), 0);

        // eight more accumulate passes drive entries into saturation
        for (int p = 0; p < 8; p++) pass(1'b1, 1, 17'h1FFFF, 1'b0);
        rd_chk(7'd5);
        chk("ent5_sat", ref_mem[5], MAXV);
        idle(0);
        tick();
        chk("ovf_sticky", 32'(ovf), 1);

        // random overwrite and accumulate passes with valid gaps
        pass(1'b0, 2, '0, 1'b1);
        rd_all();
        pass(1'b1, 2, '0, 1'b1);
        rd_all();

        // in_valid pattern 1,0,0,1
        do_start(1'b0);
        beat(17'h00123, 1'b0);
        idle(2);
        beat(17'h00456, 1'b0);
        rd_chk(7'd0);
        rd_chk(7'd1);
        rd_chk(7'd2);
        rest_random();

        // reset after 40 accepted beats
        do_start(1'b0);
        for (int i = 0; i < 40; i++) beat(17'($urandom), 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_ready", 32'(in_ready), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 0);
        rd_all();
        pass(1'b0, 0, '0, 1'b0);
        rd_chk(7'd0);
        rd_chk(7'd39);
        rd_chk(7'd100);

        // read-before-write on address 3
        do_start(1'b0);
        for (int i = 0; i < 3; i++) beat(17'($urandom), 1'b0);
        old3 = ref_mem[3];
        chk("old3_is_3", old3, 3);
        rd_adr = 7'd3;
        beat(17'h000AA, 1'b0);
        chk("rbw_old", 32'(rd_data), old3);
        tick();
        chk("rbw_new", 32'(rd_data), 32'h000AA);
        rest_random();

        // start during WRITE at beat 10 is ignored
        do_start(1'b1);
        for (int i = 0; i < 128; i++) beat(17'($urandom), i == 10);
        chk("start_ignored_done", 32'(done), 1);
        rd_all();

        // start with in_valid in DONE: beat not accepted
        start = 1'b1;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = 17'h15555;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        mw = 0;
        mode_m = 0;
        ovf_m = 0;
        chk("sv_busy", 32'(busy), 1);
        rd_chk(7'd0);
        beat(17'h00077, 1'b0);
        rd_chk(7'd0);
        rd_chk(7'd1);
        rest_random();
        chk("final_done", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
